// File: rtl/tff_count_ctrl_pkg.sv
// Shared definitions for the T-flip-flop counter controller.
package tff_count_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam int unsigned DefaultWidth = 4;
   localparam int unsigned DefaultMod   = 10;

   typedef enum logic [1:0] {
      StIdle   = ST_IDLE,
      StRun    = ST_RUN,
      StPause  = ST_PAUSE,
      StUnused = 2'd3
   } state_e;

endpackage

// File: rtl/tff_count_ctrl_tff_cell.sv
// Single T flip-flop: async active-low reset, synchronous clear, toggle on t_i.
module tff_cell (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic t_i,
   output logic q_o
);

   logic q_q;

   // Clear wins over toggle so a cleared cell always lands on 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= 1'b0;
      end else if (clr_i) begin
         q_q <= 1'b0;
      end else if (t_i) begin
         q_q <= ~q_q;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Run/pause controller driving a bank of T flip-flops as a modulo-MOD up/down counter.
module tff_count_ctrl
   import tff_count_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned MOD   = DefaultMod
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             clr_i,
   input  logic             up_dn_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             busy_o
);

   if (MOD < 2 || MOD > (32'd1 << WIDTH)) begin : g_bad_mod
      $error("tff_count_ctrl: MOD must lie in 2..2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] toggle;
   logic             busy;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: clr never blocks a transition; it only zeroes the count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start_i) state_d = StRun;
         StRun:   if (stop_i)  state_d = StPause;
         StPause: if (start_i) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // Wrapped next count, terminal count and per-bit toggle vector.
   always_comb begin
      busy = (state_q == StRun);
      if (up_dn_i) begin
         count_next = (count_q == MaxVal) ? '0 : count_q + WIDTH'(1);
      end else begin
         count_next = (count_q == '0) ? MaxVal : count_q - WIDTH'(1);
      end
      tc_o   = busy && (up_dn_i ? (count_q == MaxVal) : (count_q == '0));
      // A stop edge holds the value; clear goes through the cell clear path.
      toggle = (busy && !stop_i && !clr_i) ? (count_q ^ count_next) : '0;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .clr_i  (clr_i),
         .t_i    (toggle[i]),
         .q_o    (count_q[i])
      );
   end

   assign count_o = count_q;
   assign busy_o  = busy;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench for tff_count_ctrl against a counter-level reference model.
module tb_tff_count_ctrl;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         stop  = 1'b0;
   logic         clr   = 1'b0;
   logic         up_dn = 1'b1;
   logic [W-1:0] count;
   logic         tc;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: "counting" flag plus an integer count.
   bit m_run = 1'b0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   tff_count_ctrl #(
      .WIDTH (W),
      .MOD   (M)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start),
      .stop_i  (stop),
      .clr_i   (clr),
      .up_dn_i (up_dn),
      .count_o (count),
      .tc_o    (tc),
      .busy_o  (busy)
   );

   function automatic logic [W+1:0] exp_vec();
      logic [W-1:0] c;
      logic         t;
      c = m_cnt[W-1:0];
      t = m_run && (up_dn ? (m_cnt == M - 1) : (m_cnt == 0));
      return {c, m_run, t};
   endfunction

   task automatic model_edge();
      bit was_run;
      was_run = m_run;
      m_run   = was_run ? !stop : start;
      if (clr) begin
         m_cnt = 0;
      end else if (was_run && !stop) begin
         if (up_dn) m_cnt = (m_cnt == M - 1) ? 0 : m_cnt + 1;
         else       m_cnt = (m_cnt == 0) ? M - 1 : m_cnt - 1;
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0;
      m_cnt = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({count, busy, tc} !== {W'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset[%0d]: got count=%0d busy=%b tc=%b, want 0/0/0", i, count, busy, tc);
         end
         tick();
      end
   endtask

   task automatic test_count_up();
      rst_n = 1'b1;
      up_dn = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if ({count, busy} !== {W'(0), 1'b1}) begin
         n_fail++;
         $display("FAIL start_latency: got count=%0d busy=%b, want 0/1", count, busy);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         n_cmp++;
         if ({count, busy, tc} !== exp_vec() || count !== W'((i + 1) % M)
             || tc !== (count == W'(M - 1))) begin
            n_fail++;
            $display("FAIL count_up[%0d]: got count=%0d tc=%b, want count=%0d tc=%b",
                     i, count, tc, (i + 1) % M, ((i + 1) % M) == M - 1);
         end
      end
   endtask

   task automatic test_down_wrap();
      int exp_seq[3] = '{9, 8, 7};
      clr = 1'b1;
      tick();
      clr   = 1'b0;
      up_dn = 1'b0;
      #1;
      n_cmp++;
      if ({count, busy, tc} !== {W'(0), 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL down_tc: got count=%0d busy=%b tc=%b, want 0/1/1", count, busy, tc);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({count, busy, tc} !== exp_vec() || count !== W'(exp_seq[i])) begin
            n_fail++;
            $display("FAIL down_wrap[%0d]: got count=%0d tc=%b, want %0d", i, count, tc, exp_seq[i]);
         end
      end
   endtask

   task automatic test_pause();
      up_dn = 1'b1;
      clr   = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({count, busy, tc} !== {W'(5), 1'b0, 1'b0} || {count, busy, tc} !== exp_vec()) begin
            n_fail++;
            $display("FAIL pause_hold[%0d]: got count=%0d busy=%b, want 5/0", i, count, busy);
         end
         if (i < 3) tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if ({count, busy} !== {W'(5), 1'b1}) begin
         n_fail++;
         $display("FAIL resume_edge: got count=%0d busy=%b, want 5/1", count, busy);
      end
      tick();
      n_cmp++;
      if ({count, busy, tc} !== exp_vec() || count !== W'(6)) begin
         n_fail++;
         $display("FAIL resume_step: got count=%0d, want 6", count);
      end
   endtask

   task automatic test_priority();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      {clr, stop, start} = 3'b111;
      tick();
      {clr, stop, start} = 3'b000;
      n_cmp++;
      if ({count, busy, tc} !== {W'(0), 1'b0, 1'b0} || {count, busy, tc} !== exp_vec()) begin
         n_fail++;
         $display("FAIL prio_run: got count=%0d busy=%b, want 0/0", count, busy);
      end
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
      {clr, start} = 2'b11;
      tick();
      {clr, start} = 2'b00;
      n_cmp++;
      if ({count, busy} !== {W'(0), 1'b1}) begin
         n_fail++;
         $display("FAIL prio_idle: got count=%0d busy=%b, want 0/1", count, busy);
      end
      tick();
      n_cmp++;
      if ({count, busy, tc} !== exp_vec() || count !== W'(1)) begin
         n_fail++;
         $display("FAIL prio_idle_step: got count=%0d, want 1", count);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) tick();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({count, busy, tc} !== {W'(0), 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got count=%0d busy=%b tc=%b, want 0/0/0", count, busy, tc);
      end
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({count, busy, tc} !== {W'(0), 1'b0, 1'b0} || {count, busy, tc} !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset_idle[%0d]: got count=%0d busy=%b, want 0/0", i, count, busy);
         end
      end
   endtask

   task automatic test_direction_flip();
      int exp_seq[4] = '{4, 3, 4, 3};
      up_dn = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      for (int i = 0; i < 4; i++) begin
         up_dn = (i % 2 == 0);
         tick();
         n_cmp++;
         if ({count, busy, tc} !== exp_vec() || count !== W'(exp_seq[i])) begin
            n_fail++;
            $display("FAIL dir_flip[%0d]: got count=%0d, want %0d", i, count, exp_seq[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 7) == 0);
         clr   = ($urandom_range(0, 15) == 0);
         up_dn = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 49) == 0) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
         end else begin
            rst_n = 1'b1;
         end
         tick();
         n_cmp++;
         if ({count, busy, tc} !== exp_vec() || count >= W'(M)) begin
            n_fail++;
            $display("FAIL random[%0d]: got count=%0d busy=%b tc=%b, want count=%0d busy=%b tc=%b",
                     i, count, busy, tc, m_cnt, m_run, exp_vec() & (W + 2)'(1));
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_down_wrap();
      test_pause();
      test_priority();
      test_mid_reset();
      test_direction_flip();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
